// File: rtl/pll_lock_rst_seq_if.sv
// rtl/pll_lock_rst_seq_if.sv - PLL lock/reset sequencer signal bundle (PLL side and SoC reset side)
interface pll_lock_rst_seq_if #(
    parameter int LOSS_W = 8
);
    logic              pll_locked;
    logic              pll_rst;
    logic              sys_rst_n;
    logic              lock_ok;
    logic [LOSS_W-1:0] loss_count;
    logic [LOSS_W-1:0] timeouts;

    modport master (
        input  pll_locked,
        output pll_rst,
        output sys_rst_n,
        output lock_ok,
        output loss_count,
        output timeouts
    );

    modport slave (
        output pll_locked,
        input  pll_rst,
        input  sys_rst_n,
        input  lock_ok,
        input  loss_count,
        input  timeouts
    );
endinterface

// File: rtl/pll_lock_rst_seq.sv
// rtl/pll_lock_rst_seq.sv - PLL reset/lock sequencer; lock watchdog enabled by PLL_LOCK_WATCHDOG_EN
module pll_lock_rst_seq #(
    parameter int SYNC_STAGES        = 2,
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int LOCK_TIMEOUT       = 65536,
    parameter int CNT_W              = 17,
    parameter int LOSS_W             = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pll_lock_rst_seq_if.master   bus
);

    typedef enum logic [1:0] {
        S_PLL_RST   = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_STABLE    = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
`ifdef PLL_LOCK_WATCHDOG_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
`endif

    if (SYNC_STAGES < 2 || PLL_RST_CYCLES < 1 || LOCK_STABLE_CYCLES < 1 || LOCK_TIMEOUT < 1 ||
        longint'(PLL_RST_CYCLES) > (longint'(1) << CNT_W) ||
        longint'(LOCK_STABLE_CYCLES) > (longint'(1) << CNT_W) ||
        longint'(LOCK_TIMEOUT) > (longint'(1) << CNT_W)) begin : g_bad_cfg
        $error("pll_lock_rst_seq: parameter out of range");
    end

    state_t                  state, state_nx;
    logic [CNT_W-1:0]        cnt, cnt_nx;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    lk;
    logic                    pll_rst_q, pll_rst_nx;
    logic                    sys_rst_q, sys_rst_nx;
    logic                    lock_ok_q, lock_ok_nx;
    logic [LOSS_W-1:0]       loss_q, loss_nx;
    logic [LOSS_W-1:0]       to_q, to_nx;

    // LOCK is asynchronous to clk; only the last stage is ever looked at.
    assign lk = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_PLL_RST;
            cnt       <= '0;
            sync_q    <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b0;
            lock_ok_q <= 1'b0;
            loss_q    <= '0;
            to_q      <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
            pll_rst_q <= pll_rst_nx;
            sys_rst_q <= sys_rst_nx;
            lock_ok_q <= lock_ok_nx;
            loss_q    <= loss_nx;
            to_q      <= to_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        pll_rst_nx = 1'b0;
        sys_rst_nx = 1'b0;
        lock_ok_nx = 1'b0;
        loss_nx    = loss_q;
        to_nx      = to_q;
        case (state)
            S_PLL_RST: begin
                pll_rst_nx = 1'b1;
                cnt_nx     = cnt + 1'b1;
                if (cnt == PLL_RST_LAST) begin
                    cnt_nx     = '0;
                    pll_rst_nx = 1'b0;
                    state_nx   = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                if (lk) begin
                    cnt_nx   = '0;
                    state_nx = S_STABLE;
                end
`ifdef PLL_LOCK_WATCHDOG_EN
                else if (cnt == TIMEOUT_LAST) begin
                    // PLL never locked: pulse its reset again and log the expiry.
                    to_nx      = (to_q == '1) ? to_q : to_q + 1'b1;
                    cnt_nx     = '0;
                    pll_rst_nx = 1'b1;
                    state_nx   = S_PLL_RST;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
`endif
            end
            S_STABLE: begin
                if (!lk) begin
                    cnt_nx   = '0;
                    state_nx = S_WAIT_LOCK;
                end else if (cnt == STABLE_LAST) begin
                    cnt_nx     = '0;
                    sys_rst_nx = 1'b1;
                    lock_ok_nx = 1'b1;
                    state_nx   = S_RUN;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_RUN: begin
                if (!lk) begin
                    // Lock lost: hold the SoC in reset but leave the PLL alone.
                    loss_nx  = (loss_q == '1) ? loss_q : loss_q + 1'b1;
                    cnt_nx   = '0;
                    state_nx = S_WAIT_LOCK;
                end else begin
                    sys_rst_nx = 1'b1;
                    lock_ok_nx = 1'b1;
                end
            end
            default: begin
                pll_rst_nx = 1'b1;
                cnt_nx     = '0;
                state_nx   = S_PLL_RST;
            end
        endcase
    end

    assign bus.pll_rst    = pll_rst_q;
    assign bus.sys_rst_n  = sys_rst_q;
    assign bus.lock_ok    = lock_ok_q;
    assign bus.loss_count = loss_q;
`ifdef PLL_LOCK_WATCHDOG_EN
    assign bus.timeouts   = to_q;
`else
    assign bus.timeouts   = '0;
`endif

endmodule
